writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/writeback.sv | 159 +++++++++++++++
 tb/tb_writeback.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// writeback -- single-stage register-file writeback for an RV32 pipeline.
//
// Takes the instruction presented by the memory stage, chooses its result
// (ALU / aligned load / PC+4 / CSR) and registers the register-file write,
// the retire pulse and the misaligned-load trap pulse. Latency is one cycle.
//
// Ports:
//   i_clk, i_rst_n           clock, async active-low reset
//   i_valid, i_flush         accept = i_valid & ~i_flush
//   i_rd_addr, i_rd_we       destination register and its write request
//   i_wb_sel                 00 ALU, 01 load, 10 PC+4, 11 CSR
//   i_alu_result, i_pc_plus4, i_csr_rdata, i_load_word   candidate results
//   i_load_funct3, i_addr_lo load width/sign and byte offset
//   i_instret_we/_wdata      minstret (bit0) / minstreth (bit1) CSR writes
//   o_rf_we/_waddr/_wdata    register-file write port (also forwarding value)
//   o_retire, o_misaligned   one-cycle pulses
//   o_instret                retired-instruction count
//
// Optional feature: define WB_INSTRET_EN to build the retired-instruction
// counter. Without it o_instret is tied to 0 and the CSR inputs are ignored.

module writeback #(
  parameter int INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_flush,
  input  logic [4:0]           i_rd_addr,
  input  logic                 i_rd_we,
  input  logic [1:0]           i_wb_sel,
  input  logic [31:0]          i_alu_result,
  input  logic [31:0]          i_pc_plus4,
  input  logic [31:0]          i_csr_rdata,
  input  logic [31:0]          i_load_word,
  input  logic [2:0]           i_load_funct3,
  input  logic [1:0]           i_addr_lo,
  input  logic [1:0]           i_instret_we,
  input  logic [31:0]          i_instret_wdata,
  output logic                 o_rf_we,
  output logic [4:0]           o_rf_waddr,
  output logic [31:0]          o_rf_wdata,
  output logic                 o_retire,
  output logic                 o_misaligned,
  output logic [INSTRET_W-1:0] o_instret
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_LD  = 2'b01;
  localparam logic [1:0] SEL_PC4 = 2'b10;

  logic        accept, is_load, misal, retire_d, rf_we_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data, result;

  assign accept  = i_valid & ~i_flush;
  assign is_load = (i_wb_sel == SEL_LD);

  // Byte lane picked by the full offset, halfword lane by offset[1].
  always_comb begin
    ld_byte = 8'h00;
    case (i_addr_lo)
      2'd0: ld_byte = i_load_word[7:0];
      2'd1: ld_byte = i_load_word[15:8];
      2'd2: ld_byte = i_load_word[23:16];
      2'd3: ld_byte = i_load_word[31:24];
      default: ld_byte = 8'h00;
    endcase
  end

  assign ld_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

  // Unlisted funct3 codes fall into the word path, including its alignment rule.
  always_comb begin
    ld_data = i_load_word;
    misal   = 1'b0;
    case (i_load_funct3)
      3'b000: ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100: ld_data = {24'h0, ld_byte};
      3'b001: begin
        ld_data = {{16{ld_half[15]}}, ld_half};
        misal   = i_addr_lo[0];
      end
      3'b101: begin
        ld_data = {16'h0, ld_half};
        misal   = i_addr_lo[0];
      end
      default: begin
        ld_data = i_load_word;
        misal   = (i_addr_lo != 2'b00);
      end
    endcase
    misal = misal & is_load;
  end

  always_comb begin
    result = i_csr_rdata;
    case (i_wb_sel)
      SEL_ALU: result = i_alu_result;
      SEL_LD:  result = ld_data;
      SEL_PC4: result = i_pc_plus4;
      default: result = i_csr_rdata;
    endcase
  end

  // A trapped load neither writes nor retires; x0 writes are dropped but retire.
  assign retire_d = accept & ~misal;
  assign rf_we_d  = retire_d & i_rd_we & (i_rd_addr != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rf_we      <= 1'b0;
      o_retire     <= 1'b0;
      o_misaligned <= 1'b0;
      o_rf_waddr   <= 5'd0;
      o_rf_wdata   <= 32'd0;
    end else begin
      o_rf_we      <= rf_we_d;
      o_retire     <= retire_d;
      o_misaligned <= accept & misal;
      // Address/data hold between writes so forwarding sees the last value.
      if (rf_we_d) begin
        o_rf_waddr <= i_rd_addr;
        o_rf_wdata <= result;
      end
    end
  end

`ifdef WB_INSTRET_EN
  logic [INSTRET_W-1:0] cnt, cnt_base, wr_mask, wr_val;

  // Written halves take the CSR data; unwritten halves keep their value
  // (no increment is applied on a CSR-write cycle).
  if (INSTRET_W > 32) begin : g_hi
    assign wr_mask = {{(INSTRET_W-32){i_instret_we[1]}}, {32{i_instret_we[0]}}};
    assign wr_val  = {i_instret_wdata[INSTRET_W-33:0], i_instret_wdata};
  end else begin : g_lo
    logic unused_hi_we;
    assign unused_hi_we = i_instret_we[1];
    assign wr_mask = {32{i_instret_we[0]}};
    assign wr_val  = i_instret_wdata;
  end

  assign cnt_base = (wr_mask != '0) ? cnt : cnt + INSTRET_W'(retire_d);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt <= '0;
    else          cnt <= (cnt_base & ~wr_mask) | (wr_val & wr_mask);
  end

  assign o_instret = cnt;
`else
  logic unused_instret;
  assign unused_instret = ^{i_instret_we, i_instret_wdata};
  assign o_instret      = '0;
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_flush, i_rd_we;
  logic [4:0]  i_rd_addr;
  logic [1:0]  i_wb_sel, i_addr_lo, i_instret_we;
  logic [31:0] i_alu_result, i_pc_plus4, i_csr_rdata, i_load_word, i_instret_wdata;
  logic [2:0]  i_load_funct3;
  logic        o_rf_we, o_retire, o_misaligned;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic [63:0] o_instret;

  int total = 0;
  int bad   = 0;

  // Expected state of the behavioural model.
  logic        e_we, e_retire, e_mis;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [63:0] e_cnt;

  writeback #(.INSTRET_W(64)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_flush(i_flush),
    .i_rd_addr(i_rd_addr), .i_rd_we(i_rd_we), .i_wb_sel(i_wb_sel),
    .i_alu_result(i_alu_result), .i_pc_plus4(i_pc_plus4), .i_csr_rdata(i_csr_rdata),
    .i_load_word(i_load_word), .i_load_funct3(i_load_funct3), .i_addr_lo(i_addr_lo),
    .i_instret_we(i_instret_we), .i_instret_wdata(i_instret_wdata),
    .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_retire(o_retire), .o_misaligned(o_misaligned), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_clear();
    e_we = 0; e_retire = 0; e_mis = 0; e_waddr = 0; e_wdata = 0; e_cnt = 0;
  endtask

  // Reference behaviour from the written rules, evaluated on the current inputs.
  task automatic model_edge();
    bit acc, mis, ld, lw_like;
    int unsigned f, off, byte_v, half_v;
    logic [31:0] res;
    acc = i_valid && !i_flush;
    ld  = (i_wb_sel == 2'd1);
    f   = i_load_funct3;
    off = i_addr_lo;
    byte_v = (i_load_word >> (8 * off)) & 32'hFF;
    half_v = (i_load_word >> (16 * (off / 2))) & 32'hFFFF;
    lw_like = !(f == 0 || f == 1 || f == 4 || f == 5);
    mis = 0;
    res = 0;
    if (ld) begin
      if ((f == 1 || f == 5) && (off % 2 == 1)) mis = 1;
      if (lw_like && off != 0) mis = 1;
      if (f == 0)      res = (byte_v >= 128) ? byte_v - 256 : byte_v;
      else if (f == 4) res = byte_v;
      else if (f == 1) res = (half_v >= 32768) ? half_v - 65536 : half_v;
      else if (f == 5) res = half_v;
      else             res = i_load_word;
    end else if (i_wb_sel == 2'd0) res = i_alu_result;
    else if (i_wb_sel == 2'd2)     res = i_pc_plus4;
    else                           res = i_csr_rdata;
    e_retire = acc && !mis;
    e_mis    = acc && mis;
    e_we     = e_retire && i_rd_we && (i_rd_addr != 0);
    if (e_we) begin
      e_waddr = i_rd_addr;
      e_wdata = res;
    end
`ifdef WB_INSTRET_EN
    if (i_instret_we != 0) begin
      if (i_instret_we[0]) e_cnt[31:0]  = i_instret_wdata;
      if (i_instret_we[1]) e_cnt[63:32] = i_instret_wdata;
    end else if (e_retire) e_cnt = e_cnt + 1;
`else
    e_cnt = 0;
`endif
  endtask

  task automatic idle();
    i_valid = 0; i_flush = 0; i_rd_addr = 0; i_rd_we = 0; i_wb_sel = 0;
    i_alu_result = 0; i_pc_plus4 = 0; i_csr_rdata = 0; i_load_word = 0;
    i_load_funct3 = 0; i_addr_lo = 0; i_instret_we = 0; i_instret_wdata = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] v);
    idle();
    i_valid = 1; i_rd_we = 1; i_rd_addr = rd; i_wb_sel = 0; i_alu_result = v;
  endtask

  task automatic set_load(input logic [2:0] f, input logic [1:0] lo, input logic [31:0] w);
    idle();
    i_valid = 1; i_rd_we = 1; i_rd_addr = 5'd9; i_wb_sel = 1;
    i_load_funct3 = f; i_addr_lo = lo; i_load_word = w;
  endtask

  task automatic test_reset();
    idle();
    i_rst_n = 0;
    model_clear();
    #12;
    total++;
    if ({o_rf_we, o_retire, o_misaligned, o_rf_waddr, o_rf_wdata, o_instret} !== '0) begin
      bad++;
      $display("FAIL reset_state: got we=%b ret=%b mis=%b wa=%0d wd=%h cnt=%h, need all 0",
               o_rf_we, o_retire, o_misaligned, o_rf_waddr, o_rf_wdata, o_instret);
    end
    @(negedge i_clk);
    i_rst_n = 1;
  endtask

  task automatic test_alu();
    set_alu(5'd5, 32'h1234_5678);
    step();
    total++;
    if (o_rf_we !== 1 || o_rf_waddr !== 5 || o_rf_wdata !== 32'h1234_5678 || o_retire !== 1) begin
      bad++;
      $display("FAIL alu_write: got we=%b wa=%0d wd=%h ret=%b, need 1/5/12345678/1",
               o_rf_we, o_rf_waddr, o_rf_wdata, o_retire);
    end
    idle();
    step();
    total++;
    if (o_rf_we !== 0 || o_retire !== 0 || o_rf_wdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL alu_after: got we=%b ret=%b wd=%h, need 0/0/12345678 held",
               o_rf_we, o_retire, o_rf_wdata);
    end
  endtask

  task automatic test_loads();
    logic [31:0] w;
    logic [2:0]  f_tab [3];
    logic [1:0]  a_tab [3];
    logic [31:0] x_tab [3];
    w = 32'h80FF_7F01;
    f_tab[0] = 3'b000; a_tab[0] = 2'd3; x_tab[0] = 32'hFFFF_FF80;
    f_tab[1] = 3'b100; a_tab[1] = 2'd2; x_tab[1] = 32'h0000_00FF;
    f_tab[2] = 3'b001; a_tab[2] = 2'd2; x_tab[2] = 32'hFFFF_80FF;
    for (int k = 0; k < 3; k++) begin
      set_load(f_tab[k], a_tab[k], w);
      step();
      total++;
      if (o_rf_wdata !== x_tab[k] || o_rf_we !== 1 || o_retire !== 1 || o_misaligned !== 0) begin
        bad++;
        $display("FAIL load_fixed[%0d]: got wd=%h we=%b ret=%b mis=%b, need %h/1/1/0",
                 k, o_rf_wdata, o_rf_we, o_retire, o_misaligned, x_tab[k]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] cnt_before;
    idle();
    step();
    cnt_before = o_instret;
    set_load(3'b010, 2'd2, 32'hDEAD_BEEF);
    step();
    total++;
    if (o_misaligned !== 1 || o_rf_we !== 0 || o_retire !== 0 || o_instret !== cnt_before) begin
      bad++;
      $display("FAIL lw_misaligned: got mis=%b we=%b ret=%b cnt=%h, need 1/0/0 cnt=%h",
               o_misaligned, o_rf_we, o_retire, o_instret, cnt_before);
    end
    set_load(3'b111, 2'd1, 32'h1111_2222);  // unlisted code behaves as LW
    step();
    total++;
    if (o_misaligned !== 1 || o_retire !== 0) begin
      bad++;
      $display("FAIL unlisted_funct3: got mis=%b ret=%b, need 1/0", o_misaligned, o_retire);
    end
    set_load(3'b101, 2'd3, 32'h1111_2222);
    step();
    total++;
    if (o_misaligned !== 1 || o_rf_we !== 0) begin
      bad++;
      $display("FAIL lhu_misaligned: got mis=%b we=%b, need 1/0", o_misaligned, o_rf_we);
    end
  endtask

  task automatic test_rd0_flush();
    set_alu(5'd0, 32'hCAFE_F00D);
    step();
    total++;
    if (o_rf_we !== 0 || o_retire !== 1) begin
      bad++;
      $display("FAIL rd0: got we=%b ret=%b, need 0/1", o_rf_we, o_retire);
    end
    set_alu(5'd7, 32'h0BAD_0BAD);
    i_flush = 1;
    step();
    total++;
    if (o_rf_we !== 0 || o_retire !== 0 || o_misaligned !== 0 || o_rf_wdata !== e_wdata) begin
      bad++;
      $display("FAIL flush: got we=%b ret=%b mis=%b wd=%h, need 0/0/0 wd=%h",
               o_rf_we, o_retire, o_misaligned, o_rf_wdata, e_wdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      set_alu(5'(k + 1), 32'h100 + 32'(k));
      step();
      total++;
      if (o_retire !== 1 || o_rf_we !== 1 || o_rf_waddr !== 5'(k + 1) || o_rf_wdata !== 32'h100 + 32'(k)) begin
        bad++;
        $display("FAIL b2b[%0d]: got ret=%b we=%b wa=%0d wd=%h", k, o_retire, o_rf_we, o_rf_waddr, o_rf_wdata);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_flush = ($urandom_range(0, 7) == 0);
      i_rd_addr = 5'($urandom);
      i_rd_we = ($urandom_range(0, 4) != 0);
      i_wb_sel = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'($urandom);
      i_alu_result = $urandom; i_pc_plus4 = $urandom; i_csr_rdata = $urandom;
      i_load_word = $urandom; i_load_funct3 = 3'($urandom); i_addr_lo = 2'($urandom);
      i_instret_we = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'd0;
      i_instret_wdata = $urandom;
      step();
      total++;
      if (o_rf_we !== e_we || o_retire !== e_retire || o_misaligned !== e_mis ||
          o_rf_waddr !== e_waddr || o_rf_wdata !== e_wdata || o_instret !== e_cnt) begin
        bad++;
        $display("FAIL random[%0d]: got we=%b ret=%b mis=%b wa=%0d wd=%h cnt=%h need %b %b %b %0d %h %h",
                 k, o_rf_we, o_retire, o_misaligned, o_rf_waddr, o_rf_wdata, o_instret,
                 e_we, e_retire, e_mis, e_waddr, e_wdata, e_cnt);
      end
    end
    idle();
  endtask

  task automatic test_instret();
`ifdef WB_INSTRET_EN
    idle();
    i_instret_we = 2'b11; i_instret_wdata = 32'hFFFF_FFFF;
    step();
    idle();
    i_instret_we = 2'b10; i_instret_wdata = 32'h0;
    step();
    total++;
    if (o_instret !== 64'h0000_0000_FFFF_FFFF) begin
      bad++;
      $display("FAIL instret_set: got %h need 00000000ffffffff", o_instret);
    end
    set_alu(5'd3, 32'h1);
    step();
    total++;
    if (o_instret !== 64'h0000_0001_0000_0000) begin
      bad++;
      $display("FAIL instret_carry: got %h need 0000000100000000", o_instret);
    end
    set_alu(5'd3, 32'h2);
    i_instret_we = 2'b01; i_instret_wdata = 32'd7;
    step();
    total++;
    if (o_instret !== 64'h0000_0001_0000_0007) begin
      bad++;
      $display("FAIL instret_override: got %h need 0000000100000007", o_instret);
    end
`else
    set_alu(5'd3, 32'h1);
    i_instret_we = 2'b11; i_instret_wdata = 32'hFFFF_FFFF;
    step();
    total++;
    if (o_instret !== 64'h0) begin
      bad++;
      $display("FAIL instret_off: got %h need 0", o_instret);
    end
`endif
    idle();
  endtask

  task automatic test_async_reset();
    set_alu(5'd12, 32'hA5A5_5A5A);
    step();                       // outputs now high from the accept
    #3;
    i_rst_n = 0;                  // mid-cycle, next accept still pending
    model_clear();
    #1;
    total++;
    if ({o_rf_we, o_retire, o_misaligned, o_rf_waddr, o_rf_wdata, o_instret} !== '0) begin
      bad++;
      $display("FAIL async_reset: got we=%b ret=%b wa=%0d wd=%h cnt=%h, need all 0",
               o_rf_we, o_retire, o_rf_waddr, o_rf_wdata, o_instret);
    end
    @(posedge i_clk);
    #1;
    total++;
    if (o_retire !== 0 || o_rf_we !== 0) begin
      bad++;
      $display("FAIL reset_held_edge: got ret=%b we=%b, need 0/0", o_retire, o_rf_we);
    end
    #3;
    idle();
    i_rst_n = 1;
    step();
    total++;
    if (o_retire !== 0 || o_rf_we !== 0 || o_rf_wdata !== 0) begin
      bad++;
      $display("FAIL after_release: got ret=%b we=%b wd=%h, need 0/0/0", o_retire, o_rf_we, o_rf_wdata);
    end
    set_alu(5'd4, 32'h77);
    step();
    total++;
    if (o_retire !== 1 || o_rf_wdata !== 32'h77) begin
      bad++;
      $display("FAIL first_accept: got ret=%b wd=%h, need 1/77", o_retire, o_rf_wdata);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_misaligned();
    test_rd0_flush();
    test_back_to_back();
    test_instret();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
